// File: rtl/indexed_reg_array_pkg.sv
// Shared definitions for the indexed register-file array: default geometry,
// the depth helper and the per-entry update action.
package indexed_reg_array_pkg;

  // Default geometry: one data bit per entry, eight entries.
  localparam int DEFAULT_WIDTH       = 1;
  localparam int DEFAULT_INDEX_WIDTH = 3;

  // What a single entry does at the next rising edge.
  typedef enum logic [1:0] {
    ENTRY_HOLD       = 2'd0,
    ENTRY_LOAD       = 2'd1,
    ENTRY_INVALIDATE = 2'd2
  } entry_action_e;

  // Number of entries addressed by an index of the given width.
  function automatic int depth_of(input int index_width);
    return 1 << index_width;
  endfunction

endpackage

// File: rtl/indexed_reg_array_entry.sv
// One storage slot of the indexed register array: a width-bit data register
// plus its valid bit, both cleared by the asynchronous active-low reset.
// Loading sets the valid bit; invalidating drops it but keeps the data.
module indexed_reg_array_entry
  import indexed_reg_array_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  entry_action_e    action,
  input  logic [width-1:0] datain,
  output logic [width-1:0] data,
  output logic             valid
);

  // Data and valid register for this slot; reset dominates any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      case (action)
        ENTRY_LOAD: begin
          data  <= datain;
          valid <= 1'b1;
        end
        ENTRY_INVALIDATE: begin
          valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/indexed_reg_array.sv
// Indexed register-file array: 2^index_width entries of width bits sharing a
// single index for the combinational read and the synchronous write. Each
// entry carries a valid bit; clear flash-invalidates every valid bit while a
// simultaneous write still lands (and stays valid) at the addressed entry.
//
// Optional build macro INDEXED_REG_ARRAY_WRITE_BYPASS_EN: when defined, a
// write forwards datain (and valid=1) to the outputs in the write cycle.
// When undefined, the outputs always show the stored contents.
module indexed_reg_array
  import indexed_reg_array_pkg::*;
#(
  parameter int width       = DEFAULT_WIDTH,
  parameter int index_width = DEFAULT_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write,
  input  logic [index_width-1:0] index,
  input  logic [width-1:0]       datain,
  input  logic                   clear,
  output logic [width-1:0]       dataout,
  output logic                   valid
);

  localparam int depth = depth_of(index_width);

  logic [depth-1:0][width-1:0] entry_data;
  logic [depth-1:0]            valid_bits;

  for (genvar e = 0; e < depth; e++) begin : g_entry
    localparam logic [index_width-1:0] ENTRY_INDEX = index_width'(e);

    entry_action_e action;
    logic [width-1:0] slot_data;
    logic             slot_valid;

    // Decode this slot's update: an addressed write beats clear, otherwise clear invalidates.
    always_comb begin
      action = ENTRY_HOLD;
      if (write && (index == ENTRY_INDEX)) begin
        action = ENTRY_LOAD;
      end else if (clear) begin
        action = ENTRY_INVALIDATE;
      end
    end

    indexed_reg_array_entry #(
      .width(width)
    ) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .action (action),
      .datain (datain),
      .data   (slot_data),
      .valid  (slot_valid)
    );

    assign entry_data[e] = slot_data;
    assign valid_bits[e] = slot_valid;
  end

`ifdef INDEXED_REG_ARRAY_WRITE_BYPASS_EN
  // Combinational read with write-through: a live write is forwarded in its own cycle.
  always_comb begin
    dataout = entry_data[index];
    valid   = valid_bits[index];
    if (write && rst_n) begin
      dataout = datain;
      valid   = 1'b1;
    end
  end
`else
  // Combinational read of the stored contents; a write becomes visible after the edge.
  always_comb begin
    dataout = entry_data[index];
    valid   = valid_bits[index];
  end
`endif

  // An unknown index during a write matches no slot, so storage is left intact; flag it.
  assert property (@(posedge clk) disable iff (!rst_n) write |-> !$isunknown(index));

endmodule

// File: tb/tb_indexed_reg_array.sv
// Scoreboard bench for indexed_reg_array: stimulus pushes hand-computed
// expectations into queues and fires a sample event; a separate monitor pops
// and compares against the selected DUT (32-bit wide or 4-bit narrow).
module tb_indexed_reg_array;

  logic        clk;
  logic        rst_n;

  logic        write;
  logic [2:0]  index;
  logic [31:0] datain;
  logic        clear;
  logic [31:0] dataout;
  logic        valid;

  logic        n_write;
  logic [2:0]  n_index;
  logic [3:0]  n_datain;
  logic        n_clear;
  logic [3:0]  n_dataout;
  logic        n_valid;

  int checks = 0;
  int errors = 0;

  string       name_q[$];
  bit          sel_q[$];
  logic [31:0] data_q[$];
  logic        valid_q[$];
  event        sample_ev;

  indexed_reg_array #(.width(32), .index_width(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .write   (write),
    .index   (index),
    .datain  (datain),
    .clear   (clear),
    .dataout (dataout),
    .valid   (valid)
  );

  indexed_reg_array #(.width(4), .index_width(3)) dut_narrow (
    .clk     (clk),
    .rst_n   (rst_n),
    .write   (n_write),
    .index   (n_index),
    .datain  (n_datain),
    .clear   (n_clear),
    .dataout (n_dataout),
    .valid   (n_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: on each sample request pop the expectation and compare.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      checks++;
      if (name_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_underflow: sample requested with no expectation");
      end else begin
        string       nm;
        bit          sel;
        logic [31:0] exp_d;
        logic        exp_v;
        logic [31:0] act_d;
        logic        act_v;
        nm    = name_q.pop_front();
        sel   = sel_q.pop_front();
        exp_d = data_q.pop_front();
        exp_v = valid_q.pop_front();
        act_d = sel ? {28'd0, n_dataout} : dataout;
        act_v = sel ? n_valid : valid;
        if (act_d !== exp_d || act_v !== exp_v) begin
          errors++;
          $display("[TB] FAIL %s: got data=0x%08h valid=%b, expected data=0x%08h valid=%b",
                   nm, act_d, act_v, exp_d, exp_v);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic w, input logic [2:0] idx,
                               input logic [31:0] d, input logic clr);
    write  = w;
    index  = idx;
    datain = d;
    clear  = clr;
  endtask

  task automatic applyNarrow(input logic w, input logic [2:0] idx, input logic [3:0] d);
    n_write  = w;
    n_index  = idx;
    n_datain = d;
    n_clear  = 1'b0;
  endtask

  task automatic checkOutput(input string nm, input bit sel,
                             input logic [31:0] exp_d, input logic exp_v);
    name_q.push_back(nm);
    sel_q.push_back(sel);
    data_q.push_back(exp_d);
    valid_q.push_back(exp_v);
    ->sample_ev;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wc_expect;
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0);
    applyNarrow(1'b0, 3'd0, 4'd0);
    #1;

    // Reset sweep: every entry reads zero and invalid
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'(i), 32'd0, 1'b0);
      checkOutput("reset_sweep", 1'b0, 32'd0, 1'b0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic write then read next cycle
    applyStimulus(1'b1, 3'd5, 32'hDEADBEEF, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd5, 32'd0, 1'b0);
    checkOutput("basic_read_idx5", 1'b0, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, 3'd4, 32'd0, 1'b0);
    checkOutput("basic_read_idx4", 1'b0, 32'd0, 1'b0);

    // Write-cycle visibility
    applyStimulus(1'b1, 3'd2, 32'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd2, 32'h22, 1'b0);
`ifdef INDEXED_REG_ARRAY_WRITE_BYPASS_EN
    wc_expect = 32'h22;
`else
    wc_expect = 32'h11;
`endif
    checkOutput("write_cycle_visibility", 1'b0, wc_expect, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd2, 32'd0, 1'b0);
    checkOutput("after_write_edge", 1'b0, 32'h22, 1'b1);

    // Fill all entries, then clear together with a write at index 3
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 32'h10 + 32'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 3'd3, 32'h99, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd3, 32'd0, 1'b0);
    checkOutput("clear_write_idx3", 1'b0, 32'h99, 1'b1);
    applyStimulus(1'b0, 3'd6, 32'd0, 1'b0);
    checkOutput("clear_write_idx6", 1'b0, 32'h16, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0);
    checkOutput("clear_write_idx0", 1'b0, 32'h10, 1'b0);
    applyStimulus(1'b0, 3'd7, 32'd0, 1'b0);
    checkOutput("clear_write_idx7", 1'b0, 32'h17, 1'b0);

    // Plain clear invalidates the surviving entry but keeps its data
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd3, 32'd0, 1'b0);
    checkOutput("clear_only_idx3", 1'b0, 32'h99, 1'b0);

    // Rewrite index 7 so it holds valid data before the reset
    applyStimulus(1'b1, 3'd7, 32'h77, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd7, 32'd0, 1'b0);
    checkOutput("pre_reset_idx7", 1'b0, 32'h77, 1'b1);

    // Asynchronous reset between edges while writing index 7
    applyStimulus(1'b1, 3'd7, 32'hCAFEF00D, 1'b0);
    #4;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_idx7", 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 3'd3, 32'hCAFEF00D, 1'b0);
    checkOutput("async_reset_idx3", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'd7, 32'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_idx7", 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 3'd2, 32'd0, 1'b0);
    checkOutput("post_reset_idx2", 1'b0, 32'd0, 1'b0);

    // Narrow instance: extremes of the index range, no aliasing
    applyNarrow(1'b1, 3'd7, 4'h3);
    tick();
    applyNarrow(1'b1, 3'd0, 4'hA);
    tick();
    applyNarrow(1'b0, 3'd7, 4'h0);
    checkOutput("narrow_idx7", 1'b1, 32'h3, 1'b1);
    applyNarrow(1'b0, 3'd0, 4'h0);
    checkOutput("narrow_idx0", 1'b1, 32'hA, 1'b1);
    applyNarrow(1'b0, 3'd1, 4'h0);
    checkOutput("narrow_idx1", 1'b1, 32'h0, 1'b0);
    applyNarrow(1'b0, 3'd6, 4'h0);
    checkOutput("narrow_idx6", 1'b1, 32'h0, 1'b0);

    // The wide instance must be untouched by narrow writes
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0);
    checkOutput("wide_isolated_idx0", 1'b0, 32'd0, 1'b0);

    #4;
    checks++;
    if (name_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", name_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/indexed_reg_array.md
Name: indexed_reg_array

Overview:
- Small parameterised register-file array: 2^index_width entries of `width` bits, one shared index for read and write.
- Read is combinational; write is synchronous.
- Used as the storage primitive for per-set tables: tag, state, previous-address and stride fields of the reference prediction table, one instance per way/field.
- Each entry carries a valid bit so owners can tell written entries from reset contents.

Parameters:
- width, 1, data bits per entry; legal range 1..64.
- index_width, 3, index bits; depth = 2^index_width, giving 8 entries by default.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- write  input  1  write enable; entry[index] is loaded from datain at the rising edge.
- index  input  index_width  entry select, shared by read and write.
- datain  input  width  write data.
- clear  input  1  synchronous flash-invalidate of all valid bits.
- dataout  output  width  combinational read of entry[index].
- valid  output  1  combinational valid bit of entry[index].

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - All data entries go to 0 and all valid bits go to 0.
  - dataout=0 and valid=0 while reset is held.
  - Deassertion is synchronised by the owner; the array has no reset synchroniser.
- Read:
  - dataout = data[index] and valid = valid_bits[index], purely combinational with zero-cycle latency.
  - Outputs follow index changes within the same cycle.
- Write:
  - At posedge clk, if write=1 then data[index] <= datain and valid_bits[index] <= 1.
  - Other entries are unchanged.
  - Write-then-read latency is 1 cycle: new data is visible on dataout after the edge.
  - In the write cycle itself, dataout shows the old contents (unless WRITE_BYPASS_EN is defined).
- Clear:
  - At posedge clk, if clear=1, all valid bits go to 0; data contents are retained.
  - If clear and write are both 1 in the same cycle, write wins for the addressed entry: that entry's valid bit = 1 and its data is written. All other valid bits are cleared.
- Width rules:
  - datain and dataout are exactly `width` bits.
  - Callers driving narrower values rely on standard zero-extension at the port; no truncation logic is inside the block.
- Boundary conditions:
  - Index max (2^index_width − 1) and index 0 behave identically to any other entry; there is no wrap and no out-of-range case.
  - X on index while write=1 must not corrupt the array; the simulation assertion fires.
  - If reset asserts mid-write, reset dominates; the entry stays 0 and invalid.
- No handshake: the array is always ready and writes are single-cycle.

Optional Feature:
- Macro: INDEXED_REG_ARRAY_WRITE_BYPASS_EN
- Defined:
  - When write=1 (and rst_n=1), dataout = datain and valid = 1 combinationally in the write cycle, i.e. write-through forwarding.
  - When write=0, outputs are the stored contents as normal.
- Undefined: dataout always reflects stored contents (old data during the write cycle).

Decomposition:
- Shared package indexed_reg_array_pkg holds:
  - the default width and index_width constants;
  - a localparam helper for depth = 1 << index_width.
- No sub-module is required. Storage is one generate-looped register vector per entry plus a valid vector.
- Optional sub-module reg_array_entry: one width-bit register with async reset, load enable and valid bit; instantiated depth times.

Test Plan:
- Reset: width=32; hold rst_n=0, sweep index 0..7 -> dataout=0 and valid=0 for every index.
- Basic write/read: write 0xDEADBEEF at index 5; the next cycle reads index 5 -> 0xDEADBEEF with valid=1; index 4 -> 0 with valid=0.
- Write-cycle visibility (macro undefined): index 2 holds 0x11; write 0x22 at index 2 -> dataout=0x11 during the write cycle and 0x22 after the edge. With the macro defined -> 0x22 in the same cycle.
- Clear vs write: fill indices 0..7 with 0x10+i; then pulse clear=1 together with write=1, index=3, datain=0x99 -> only index 3 valid, with data 0x99; index 6 has valid=0 and data 0x16.
- Async reset mid-operation: assert rst_n=0 between clock edges while write=1 at index 7 -> outputs go to 0 immediately; after release index 7 reads 0 with valid=0.
- Parameter sweep: width=4, index_width=3; write 0x3 at index 7 (max) and 0xA at index 0 -> both read back correctly and no aliasing occurs.
